// File: rtl/inst_fetch_queue.sv
// IF-to-ID instruction queue: DEPTH-entry first-word-fall-through FIFO of {pc, inst}.
// Flush or reset empties it in one edge; an empty queue presents a zero bubble to ID.
module inst_fetch_queue #(
    parameter int DEPTH  = 4,
    parameter int PC_W   = 32,
    parameter int INST_W = 32,
    parameter int CNT_W  = $clog2(DEPTH) + 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              in_valid,
    input  logic [PC_W-1:0]   in_pc,
    input  logic [INST_W-1:0] in_inst,
    output logic              in_ready,
    output logic              out_valid,
    output logic [PC_W-1:0]   out_pc,
    output logic [INST_W-1:0] out_inst,
    input  logic              out_ready,
    output logic [CNT_W-1:0]  count,
    output logic              full,
    output logic              empty
);

    localparam int IDX_W = $clog2(DEPTH);
    localparam int PTR_W = IDX_W + 1;

    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [PC_W-1:0]   pc_mem_q   [DEPTH];
    logic [PC_W-1:0]   pc_mem_d   [DEPTH];
    logic [INST_W-1:0] inst_mem_q [DEPTH];
    logic [INST_W-1:0] inst_mem_d [DEPTH];

    logic [IDX_W-1:0]  wr_idx;
    logic [IDX_W-1:0]  rd_idx;
    logic [PTR_W-1:0]  ptr_diff;
    logic              push;
    logic              pop;

    assign wr_idx = wr_ptr_q[IDX_W-1:0];
    assign rd_idx = rd_ptr_q[IDX_W-1:0];

    // Status comes only from registered pointers, so in_ready never depends on out_ready.
    always_comb begin
        empty    = (wr_ptr_q == rd_ptr_q);
        full     = (wr_idx == rd_idx) && (wr_ptr_q[IDX_W] != rd_ptr_q[IDX_W]);
        ptr_diff = wr_ptr_q - rd_ptr_q;
        count    = CNT_W'(ptr_diff);
        in_ready  = ~full;
        out_valid = ~empty;
        out_pc    = empty ? '0 : pc_mem_q[rd_idx];
        out_inst  = empty ? '0 : inst_mem_q[rd_idx];
        push = in_valid & in_ready & ~flush;
        pop  = out_valid & out_ready & ~flush;
    end

    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        pc_mem_d   = pc_mem_q;
        inst_mem_d = inst_mem_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
        end else begin
            if (push) begin
                pc_mem_d[wr_idx]   = in_pc;
                inst_mem_d[wr_idx] = in_inst;
                wr_ptr_d           = wr_ptr_q + 1'b1;
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                pc_mem_q[i]   <= '0;
                inst_mem_q[i] <= '0;
            end
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            pc_mem_q   <= pc_mem_d;
            inst_mem_q <= inst_mem_d;
        end
    end

endmodule

// File: tb/tb_inst_fetch_queue.sv
// Bench for inst_fetch_queue: directed scenarios plus random traffic, checked by a
// negedge monitor against a queue-based model of the expected FIFO contents.
module tb_inst_fetch_queue;

    localparam int DEPTH  = 4;
    localparam int PC_W   = 32;
    localparam int INST_W = 32;
    localparam int CNT_W  = 3;

    logic              clk = 1'b0;
    logic              rst;
    logic              flush;
    logic              in_valid;
    logic [PC_W-1:0]   in_pc;
    logic [INST_W-1:0] in_inst;
    logic              in_ready;
    logic              out_valid;
    logic [PC_W-1:0]   out_pc;
    logic [INST_W-1:0] out_inst;
    logic              out_ready;
    logic [CNT_W-1:0]  count;
    logic              full;
    logic              empty;

    inst_fetch_queue #(.DEPTH(DEPTH), .PC_W(PC_W), .INST_W(INST_W), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_pc(in_pc), .in_inst(in_inst), .in_ready(in_ready),
        .out_valid(out_valid), .out_pc(out_pc), .out_inst(out_inst), .out_ready(out_ready),
        .count(count), .full(full), .empty(empty)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [PC_W-1:0]   pc;
        logic [INST_W-1:0] inst;
    } ent_t;

    ent_t exp_q[$];
    int   n_chk  = 0;
    int   n_fail = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: compare against the model's view of the pre-edge state, then apply the edge.
    always @(negedge clk) begin
        int   sz;
        bit   do_push;
        bit   do_pop;
        ent_t e;
        sz = exp_q.size();
        chk("count", 64'(count), 64'(sz));
        chk("empty", 64'(empty), 64'(sz == 0));
        chk("full", 64'(full), 64'(sz == DEPTH));
        chk("in_ready", 64'(in_ready), 64'(sz < DEPTH));
        chk("out_valid", 64'(out_valid), 64'(sz > 0));
        if (sz > 0) begin
            chk("out_pc", 64'(out_pc), 64'(exp_q[0].pc));
            chk("out_inst", 64'(out_inst), 64'(exp_q[0].inst));
        end else begin
            chk("bubble_pc", 64'(out_pc), 64'd0);
            chk("bubble_inst", 64'(out_inst), 64'd0);
        end
        if (rst || flush) begin
            exp_q.delete();
        end else begin
            do_push = in_valid && (sz < DEPTH);
            do_pop  = out_ready && (sz > 0);
            if (do_pop) e = exp_q.pop_front();
            if (do_push) exp_q.push_back('{pc: in_pc, inst: in_inst});
        end
    end

    task automatic set_in(input logic v, input logic [31:0] pc, input logic [31:0] inst,
                          input logic rdy, input logic fl, input logic r);
        in_valid  = v;
        in_pc     = pc;
        in_inst   = inst;
        out_ready = rdy;
        flush     = fl;
        rst       = r;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [31:0] pc, input logic [31:0] inst,
                         input logic rdy, input logic fl, input logic r);
        set_in(v, pc, inst, rdy, fl, r);
        tick();
    endtask

    initial begin
        set_in(0, 0, 0, 1, 0, 1);
        tick();
        tick();

        // Reset and idle
        drive(0, 0, 0, 1, 0, 0);
        drive(0, 0, 0, 1, 0, 0);
        chk("idle_valid", 64'(out_valid), 64'd0);
        chk("idle_pc", 64'(out_pc), 64'd0);
        chk("idle_count", 64'(count), 64'd0);
        chk("idle_ready", 64'(in_ready), 64'd1);

        // Fill while ID stalls
        for (int i = 0; i < 4; i++) begin
            drive(1, 32'hBFC0_0000 + 32'(4 * i), 32'h3401_0001 + 32'(i), 0, 0, 0);
            chk("fill_count", 64'(count), 64'(i + 1));
            chk("fill_head_pc", 64'(out_pc), 64'hBFC0_0000);
            chk("fill_head_inst", 64'(out_inst), 64'h3401_0001);
        end
        chk("fill_full", 64'(full), 64'd1);
        chk("fill_in_ready", 64'(in_ready), 64'd0);
        drive(1, 32'hBFC0_0010, 32'h3401_0005, 0, 0, 0);
        chk("fifth_rejected_count", 64'(count), 64'd4);

        // Drain from full; in_ready must stay low in the first pop cycle
        set_in(0, 0, 0, 1, 0, 0);
        #1;
        chk("pop_cycle_in_ready", 64'(in_ready), 64'd0);
        tick();
        chk("after_pop_in_ready", 64'(in_ready), 64'd1);
        for (int i = 1; i < 4; i++) begin
            chk("drain_pc", 64'(out_pc), 64'hBFC0_0000 + 64'(4 * i));
            drive(0, 0, 0, 1, 0, 0);
        end
        chk("drained_count", 64'(count), 64'd0);
        chk("drained_inst", 64'(out_inst), 64'd0);

        // Streaming across pointer wrap
        for (int i = 0; i < 10; i++) begin
            drive(1, 32'(4 * i), 32'h1000 + 32'(i), 1, 0, 0);
            chk("stream_count", 64'(count), 64'd1);
            chk("stream_trail_pc", 64'(out_pc), 64'(4 * i));
        end
        drive(0, 0, 0, 1, 0, 0);

        // Flush with 3 queued and a push/pop requested in the flush cycle
        for (int i = 0; i < 3; i++) drive(1, 32'h40 + 32'(4 * i), 32'h2000 + 32'(i), 0, 0, 0);
        drive(1, 32'h4C, 32'h2003, 1, 1, 0);
        chk("flush_empty", 64'(empty), 64'd1);
        chk("flush_count", 64'(count), 64'd0);
        chk("flush_valid", 64'(out_valid), 64'd0);
        drive(1, 32'h80, 32'h2080, 0, 0, 0);
        chk("post_flush_count", 64'(count), 64'd1);
        chk("post_flush_pc", 64'(out_pc), 64'h80);
        drive(0, 0, 0, 1, 0, 0);

        // Reset mid-operation, then reset together with flush
        for (int k = 0; k < 2; k++) begin
            drive(1, 32'h100, 32'h3000, 0, 0, 0);
            drive(1, 32'h104, 32'h3001, 0, 0, 0);
            drive(1, 32'h108, 32'h3002, 1, k == 1, 1);
            chk("rst_count", 64'(count), 64'd0);
            chk("rst_valid", 64'(out_valid), 64'd0);
            chk("rst_pc", 64'(out_pc), 64'd0);
            chk("rst_inst", 64'(out_inst), 64'd0);
            chk("rst_in_ready", 64'(in_ready), 64'd1);
        end

        // Random traffic
        for (int i = 0; i < 3000; i++) begin
            drive(1'($urandom_range(0, 3) != 0), $urandom, $urandom,
                  1'($urandom_range(0, 2) != 0),
                  1'($urandom_range(0, 31) == 0),
                  1'($urandom_range(0, 127) == 0));
        end

        drive(0, 0, 0, 1, 0, 0);
        @(negedge clk);
        #1;
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
